// File: rtl/pixel_stream_tx_pkg.sv
// pixel_stream_tx_pkg: shared widths, default frame size and FSM states for pixel_stream_tx
package pixel_stream_tx_pkg;
  localparam int PIX_W = 24;
  localparam int ADDR_W = 17;
  localparam int DEF_FRAME_W = 320;
  localparam int DEF_FRAME_H = 240;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/pixel_tx_fifo.sv
// pixel_tx_fifo: first-word-fall-through pixel buffer with occupancy count
module pixel_tx_fifo
  import pixel_stream_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PIX_W-1:0] push_data,
  input  logic             pop,
  output logic [PIX_W-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && count_q != '0;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + CW'(push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end
  assign pop_data = mem[rd_ptr_q];
  assign count = count_q;
  assign empty = count_q == '0;
endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: credit-paced frame reader to a valid/ready pixel stream; PIXEL_STREAM_TX_TESTPAT_EN adds a ramp test-pattern source
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int FRAME_H = DEF_FRAME_H,
  parameter int MEM_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef PIXEL_STREAM_TX_TESTPAT_EN
  input  logic              test_pattern,
`endif
  input  logic              start,
  input  logic              continuous,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [PIX_W-1:0]  data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              sop_out,
  output logic              eop_out
);
  localparam int NUM_PIX = FRAME_W * FRAME_H;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);
  if (FIFO_DEPTH < MEM_LAT + 1) begin : g_bad_cfg
    $error("pixel_stream_tx: FIFO_DEPTH must be at least MEM_LAT+1");
  end
  state_e state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, out_idx_q, out_idx_d;
  logic [CW-1:0] outst_q, outst_d, fifo_count;
  logic issue, pop, src_valid, fifo_empty;
  logic [PIX_W-1:0] src_data, fifo_data;
`ifdef PIXEL_STREAM_TX_TESTPAT_EN
  logic tp_q, tp_d, pat_valid_q, pat_valid_d;
  logic [7:0] pat_q, pat_d;
  always_comb begin
    tp_d = (state_q == IDLE && start) ? test_pattern : tp_q;
    pat_valid_d = issue && tp_q;
    pat_d = rd_addr_q[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q <= 1'b0;
      pat_valid_q <= 1'b0;
      pat_q <= '0;
    end else begin
      tp_q <= tp_d;
      pat_valid_q <= pat_valid_d;
      pat_q <= pat_d;
    end
  end
  assign src_valid = tp_q ? pat_valid_q : mem_rd_valid && outst_q != '0;
  assign src_data = tp_q ? {3{pat_q}} : mem_rd_data;
  assign mem_rd_en = issue && !tp_q;
`else
  // returns only count against a read we issued, so stale beats after reset are dropped
  assign src_valid = mem_rd_valid && outst_q != '0;
  assign src_data = mem_rd_data;
  assign mem_rd_en = issue;
`endif
  always_comb begin
    issue = state_q == FETCH && ({1'b0, fifo_count} + {1'b0, outst_q}) < (CW + 1)'(FIFO_DEPTH);
    pop = !fifo_empty && ready_in;
    outst_d = outst_q + CW'(issue) - CW'(src_valid);
    out_idx_d = pop ? (out_idx_q == LAST ? '0 : out_idx_q + 1'b1) : out_idx_q;
    state_d = state_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        rd_addr_d = '0;
      end
      FETCH: if (issue) begin
        rd_addr_d = rd_addr_q + 1'b1;
        state_d = rd_addr_q == LAST ? DRAIN : FETCH;
      end
      DRAIN: state_d = (pop && out_idx_q == LAST) ? DONE : DRAIN;
      DONE: begin
        state_d = continuous ? FETCH : IDLE;
        rd_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      out_idx_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      rd_addr_q <= rd_addr_d;
      out_idx_q <= out_idx_d;
      outst_q <= outst_d;
    end
  end
  pixel_tx_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(src_valid),
    .push_data(src_data),
    .pop(pop),
    .pop_data(fifo_data),
    .count(fifo_count),
    .empty(fifo_empty)
  );
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign mem_addr = rd_addr_q;
  assign valid_out = !fifo_empty;
  assign data_out = fifo_empty ? '0 : fifo_data;
  assign sop_out = !fifo_empty && out_idx_q == '0;
  assign eop_out = !fifo_empty && out_idx_q == LAST;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: scoreboard bench for pixel_stream_tx on a 4x2 frame with a 2-cycle memory model
module tb_pixel_stream_tx;
  localparam int NP = 8;
  logic clk = 0, rst_n = 0, start = 0, continuous = 0, ready_in = 1;
  logic busy, frame_done, mem_rd_en, mem_rd_valid, valid_out, sop_out, eop_out;
  logic [16:0] mem_addr;
  logic [23:0] mem_rd_data, data_out;
`ifdef PIXEL_STREAM_TX_TESTPAT_EN
  logic test_pattern = 0;
`endif
  logic v1, v2;
  logic [16:0] a1, a2;
  logic [25:0] exp_q [$];
  logic [25:0] e;
  int n_checks = 0, n_fail = 0, done_cnt = 0, beats = 0;
  logic tp_mode = 0, eop_prev = 0, stall_prev = 0, h_sop = 0, h_eop = 0;
  logic [23:0] h_data = 0;

  always #5 clk = ~clk;

  pixel_stream_tx #(.FRAME_W(4), .FRAME_H(2), .MEM_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef PIXEL_STREAM_TX_TESTPAT_EN
    .test_pattern(test_pattern),
`endif
    .start(start),
    .continuous(continuous),
    .busy(busy),
    .frame_done(frame_done),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .sop_out(sop_out),
    .eop_out(eop_out)
  );

  // memory returns data == address, two cycles after the read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 0; v2 <= 0; a1 <= 0; a2 <= 0;
    end else begin
      v1 <= mem_rd_en; a1 <= mem_addr;
      v2 <= v1; a2 <= a1;
    end
  end
  assign mem_rd_valid = v2;
  assign mem_rd_data = 24'(a2);

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic push_frame(input bit pat);
    for (int i = 0; i < NP; i++) begin
      logic [7:0] b;
      b = 8'(i);
      exp_q.push_back({i == 0, i == NP - 1, pat ? {b, b, b} : 24'(i)});
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int k;
    k = 0;
    while (done_cnt < target && k < 200) begin tick(); k++; end
    check(name, done_cnt, target);
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eop_prev = 0; stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", valid_out, 1);
          check("hold_data", data_out, h_data);
          check("hold_flags", {sop_out, eop_out}, {h_sop, h_eop});
        end
        if (frame_done || eop_prev) check("frame_done_after_eop", frame_done, eop_prev);
        if (frame_done) done_cnt++;
        n_checks++;
        if (dut.u_fifo.count > 4) begin
          n_fail++;
          $display("FAIL fifo_bound: got count %0d expected <= 4", dut.u_fifo.count);
        end
        if (tp_mode) check("tp_no_mem_rd", mem_rd_en, 0);
        eop_prev = valid_out && ready_in && eop_out;
        stall_prev = valid_out && !ready_in;
        h_data = data_out; h_sop = sop_out; h_eop = eop_out;
        if (valid_out && ready_in) begin
          beats++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_beat: got data %0h expected no beat", data_out);
          end else begin
            e = exp_q.pop_front();
            if ({sop_out, eop_out, data_out} !== e) begin
              n_fail++;
              $display("FAIL beat: got sop=%0b eop=%0b data=%0h expected sop=%0b eop=%0b data=%0h",
                       sop_out, eop_out, data_out, e[25], e[24], e[23:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c, b0, k;
    #1;
    check("rst_ctrl", {busy, frame_done, mem_rd_en, valid_out, sop_out, eop_out}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", data_out, 0);
    tick(); tick(); rst_n = 1; tick();
    check("idle_busy", busy, 0);
    // single frame, ready held high
    push_frame(0); pulse_start();
    wait_done(1, "t1_done");
    tick(); tick();
    check("t1_idle", busy, 0);
    check("t1_drained", exp_q.size(), 0);
    // back-pressure on stream cycles 3..6
    push_frame(0); pulse_start();
    c = -1;
    for (int i = 0; i < 60 && done_cnt < 2; i++) begin
      if (c < 0 && valid_out) c = 0;
      ready_in = !(c >= 3 && c <= 6);
      tick();
      if (c >= 0) c++;
    end
    ready_in = 1;
    wait_done(2, "t2_done");
    tick(); tick();
    check("t2_drained", exp_q.size(), 0);
    // continuous: two frames back to back
    continuous = 1;
    push_frame(0); push_frame(0); pulse_start();
    wait_done(3, "t3_first_done");
    check("t3_restarted", busy, 1);
    continuous = 0;
    wait_done(4, "t3_second_done");
    tick(); tick();
    check("t3_idle", busy, 0);
    check("t3_drained", exp_q.size(), 0);
    // asynchronous reset at beat 3
    push_frame(0); pulse_start();
    b0 = beats; k = 0;
    while (beats < b0 + 3 && k < 100) begin tick(); k++; end
    check("t4_beat3_reached", beats - b0, 3);
    rst_n = 0; #1;
    check("t4_rst_ctrl", {busy, frame_done, mem_rd_en, valid_out, sop_out, eop_out}, 0);
    check("t4_rst_addr", mem_addr, 0);
    check("t4_rst_data", data_out, 0);
    exp_q.delete();
    tick(); rst_n = 1; tick(); tick();
    check("t4_idle_after_rst", {busy, valid_out}, 0);
    push_frame(0); pulse_start();
    wait_done(5, "t4_done");
    tick(); tick();
    check("t4_drained", exp_q.size(), 0);
    // start while fetching is ignored
    push_frame(0); pulse_start();
    tick();
    check("t5_busy", busy, 1);
    pulse_start();
    wait_done(6, "t5_done");
    repeat (20) tick();
    check("t5_one_frame", done_cnt, 6);
    check("t5_idle", busy, 0);
    check("t5_drained", exp_q.size(), 0);
`ifdef PIXEL_STREAM_TX_TESTPAT_EN
    tp_mode = 1; test_pattern = 1;
    push_frame(1); pulse_start();
    test_pattern = 0;
    wait_done(7, "t6_done");
    tick(); tick();
    tp_mode = 0;
    check("t6_drained", exp_q.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter FRAME_W, default 320, pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 240, lines per frame; NUM_PIX = FRAME_W*FRAME_H.
REQ-003 SHALL have parameter MEM_LAT, default 2, fixed cycles from mem_rd_en to mem_rd_valid.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >= MEM_LAT+1).
REQ-005 SHALL have ports: clk input 1, clock; rst_n input 1, reset, asynchronous active-low.
REQ-006 SHALL have ports: start input 1, frame request pulse; continuous input 1, auto-restart after eop.
REQ-007 SHALL have ports: busy output 1, frame in progress; frame_done output 1, one-cycle pulse after eop accepted.
REQ-008 SHALL have ports: mem_rd_en output 1; mem_addr output 17, pixel index; mem_rd_data input 24; mem_rd_valid input 1.
REQ-009 SHALL have ports: data_out output 24, {B[23:16],G[15:8],R[7:0]}; valid_out output 1; ready_in input 1; sop_out output 1; eop_out output 1.

Function
REQ-010 Transfer SHALL occur only on a cycle with valid_out=1 and ready_in=1; ready latency 0.
REQ-011 While valid_out=1 and ready_in=0, data_out, sop_out and eop_out SHALL hold stable.
REQ-012 FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-013 IDLE->FETCH SHALL occur on start=1; rd_addr SHALL clear to 0.
REQ-014 In FETCH, mem_rd_en SHALL be 1 only when fifo_count + outstanding < FIFO_DEPTH; rd_addr SHALL increment per issued read.
REQ-015 FETCH->DRAIN SHALL occur when the read with mem_addr = NUM_PIX-1 issues.
REQ-016 DRAIN->DONE SHALL occur on the transfer with eop_out=1.
REQ-017 DONE SHALL pulse frame_done for 1 cycle, then go to FETCH if continuous=1, else IDLE.
REQ-018 The mem_rd_valid beat SHALL be written into the FIFO; the FIFO SHALL never overflow, since credits bound writes.
REQ-019 sop_out SHALL be 1 only on pixel index 0; eop_out SHALL be 1 only on index NUM_PIX-1, tracked by an output-side counter.
REQ-020 The output counter SHALL wrap from NUM_PIX-1 to 0 on the eop transfer.
REQ-021 Read-to-valid_out latency SHALL be MEM_LAT+1 cycles with an empty FIFO and ready_in=1.
REQ-022 Sustained throughput SHALL be 1 pixel/cycle with ready_in held at 1.
REQ-023 start SHALL be ignored outside IDLE.
REQ-024 busy SHALL be 1 in FETCH, DRAIN and DONE.
REQ-025 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, with counters, FIFO pointers and outstanding count all 0.
REQ-027 Reset SHALL force all outputs to 0.
REQ-028 Reset mid-frame SHALL discard in-flight reads; mem_rd_valid SHALL be ignored until after the first start.

Configuration
REQ-029 With PIXEL_STREAM_TX_TESTPAT_EN defined, the block SHALL add input test_pattern (1 bit), sampled at IDLE->FETCH.
REQ-030 With test_pattern=1, the block SHALL not assert mem_rd_en; FIFO data SHALL be R=G=B=index[7:0], one cycle after credit.
REQ-031 With the macro undefined, there SHALL be no test_pattern port and no pattern logic; memory is the only source.

Structure
REQ-032 A shared package SHALL hold PIX_W=24, ADDR_W=17, the default FRAME_W/FRAME_H, and the FSM state enum.
REQ-033 The FIFO SHALL be sub-module pixel_tx_fifo, with push/pop/count and first-word-fall-through output.

Verification
REQ-034 Bench SHALL check: FRAME_W=4, FRAME_H=2, ready_in=1, start pulse -> 8 beats, sop on beat 0 only, eop on beat 7 only, frame_done 1 cycle later.
REQ-035 Bench SHALL check: ready_in low for cycles 3-6 of the stream -> data/sop/eop held, no beat lost or duplicated, fifo_count<=4.
REQ-036 Bench SHALL check: continuous=1, mem data = addr -> two back-to-back frames, data 0..7 then 0..7, with sop again on the second frame.
REQ-037 Bench SHALL check: rst_n low at beat 3 -> all outputs 0 immediately; a new start yields a full frame from addr 0.
REQ-038 Bench SHALL check: start during FETCH -> no effect; frame count stays 1.
REQ-039 Bench SHALL check, with PIXEL_STREAM_TX_TESTPAT_EN defined: test_pattern=1 -> data 0x000000, 0x010101 ... 0x070707, and mem_rd_en never 1.
